// File: rtl/dvs_ravens_pkg.sv
// Shared types and defaults for the RAVENS-side event path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dvs_ravens_pkg;

   localparam int EVENT_BITS         = 16;
   localparam int FIFO_DEPTH_DEFAULT = 16;
   localparam int NUM_EVENT_SRC      = 2;

   typedef logic [EVENT_BITS-1:0] dvs_event_t;

   // Index width that stays legal for a single requester.
   function automatic int idx_bits(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/dvs_rr_arbiter.sv
// Round-robin arbiter: one registered one-hot grant per cycle among eligible sources.
// Latency: grant is visible the cycle after eligibility is seen.
// Backpressure: enable_i low withholds the grant and freezes the rr pointer.
module dvs_rr_arbiter
   import dvs_ravens_pkg::*;
#(
   parameter int NUM_SRC = 2,
   localparam int IDX_BITS = idx_bits(NUM_SRC)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [NUM_SRC-1:0]  eligible_i,
   input  logic                enable_i,
   output logic [NUM_SRC-1:0]  grant_o,
   output logic [IDX_BITS-1:0] grant_idx_o
);

   logic [IDX_BITS-1:0] rr_q, rr_d;
   logic [NUM_SRC-1:0]  grant_q, grant_d;
   logic [IDX_BITS-1:0] idx_q, idx_d;
   logic                win_vld;
   logic [IDX_BITS-1:0] win_idx;
   logic [IDX_BITS-1:0] cand;

   // Scan from rr_q upward with wrap; the nearest eligible source wins.
   always_comb begin
      win_vld = 1'b0;
      win_idx = '0;
      cand    = '0;
      for (int k = NUM_SRC - 1; k >= 0; k--) begin
         cand = IDX_BITS'((int'(rr_q) + k) % NUM_SRC);
         if (eligible_i[cand]) begin
            win_vld = 1'b1;
            win_idx = cand;
         end
      end
   end

   // Commit the winner only when allowed; rr moves just past it.
   always_comb begin
      grant_d = '0;
      idx_d   = idx_q;
      rr_d    = rr_q;
      if (enable_i && win_vld) begin
         grant_d[win_idx] = 1'b1;
         idx_d            = win_idx;
         rr_d             = (win_idx == IDX_BITS'(NUM_SRC - 1)) ? '0 : win_idx + IDX_BITS'(1);
      end
   end

   // Grant is a single-cycle registered pulse; rst drops any in-flight grant.
   always_ff @(posedge clk) begin
      if (rst) begin
         rr_q    <= '0;
         grant_q <= '0;
         idx_q   <= '0;
      end else begin
         rr_q    <= rr_d;
         grant_q <= grant_d;
         idx_q   <= idx_d;
      end
   end

   assign grant_o     = grant_q;
   assign grant_idx_o = idx_q;

endmodule

// File: rtl/dvs_event_fifo_arbiter.sv
// Arbitrates event sources round-robin, buffers their write beats, serves a FWFT reader.
// Latency: req -> grant 1 edge; data stored 2 edges after grant rises; rd_valid the cycle after.
// Backpressure: a full buffer withholds grants; the reader stalls via rd_ready.
module dvs_event_fifo_arbiter
   import dvs_ravens_pkg::*;
#(
   parameter int NUM_SRC = NUM_EVENT_SRC,
   parameter int DEPTH   = FIFO_DEPTH_DEFAULT,
   localparam int PTR_BITS = $clog2(DEPTH)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_SRC-1:0]            src_req,
   output logic [NUM_SRC-1:0]            src_grant,
   input  logic [NUM_SRC-1:0]            src_wr_en,
   input  logic [NUM_SRC*EVENT_BITS-1:0] src_event,
   output logic                          rd_valid,
   input  logic                          rd_ready,
   output logic [EVENT_BITS-1:0]         rd_event,
   output logic [PTR_BITS:0]             count,
   output logic                          proto_err
);

   localparam int IDX_BITS = idx_bits(NUM_SRC);
   localparam int CW       = PTR_BITS + 2;

   dvs_event_t          mem_q [DEPTH];
   logic [PTR_BITS-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_BITS-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_BITS:0]   count_q, count_d;
   logic                exp_vld_q;
   logic [IDX_BITS-1:0] exp_idx_q;
   logic                proto_err_q, proto_err_d;

   logic [NUM_SRC-1:0]  grant;
   logic [IDX_BITS-1:0] grant_idx;
   logic [NUM_SRC-1:0]  eligible;
   logic [NUM_SRC-1:0]  exp_mask;
   dvs_event_t          wr_data;
   logic                pending;
   logic                wr_fire;
   logic                rd_fire;
   logic                miss;
   logic                stray;
   logic                space_ok;
   logic [CW-1:0]       committed;

   // A source granted this cycle still holds req; mask it so it is not granted twice.
   assign eligible = src_req & ~grant;

   dvs_rr_arbiter #(
      .NUM_SRC(NUM_SRC)
   ) u_arb (
      .clk         (clk),
      .rst         (rst),
      .eligible_i  (eligible),
      .enable_i    (space_ok),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   // Select the expected source's beat and flag wr_en from anyone else.
   always_comb begin
      exp_mask = '0;
      wr_data  = '0;
      for (int k = 0; k < NUM_SRC; k++) begin
         if (exp_vld_q && (IDX_BITS'(k) == exp_idx_q)) begin
            exp_mask[k] = 1'b1;
            wr_data     = src_event[k*EVENT_BITS +: EVENT_BITS];
         end
      end
   end

   assign pending  = |grant;
   assign wr_fire  = exp_vld_q & src_wr_en[exp_idx_q];
   assign miss     = exp_vld_q & ~src_wr_en[exp_idx_q];
   assign stray    = |(src_wr_en & ~exp_mask);
   assign rd_fire  = rd_valid & rd_ready;

   // Everything already promised to the buffer after this edge; a new grant needs one more slot.
   assign committed = CW'(count_q) + CW'(pending) + CW'(wr_fire) - CW'(rd_fire);
   assign space_ok  = committed < CW'(DEPTH);

   // Pointer/count bookkeeping; simultaneous write and pop leaves count unchanged.
   always_comb begin
      wr_ptr_d    = wr_fire ? wr_ptr_q + PTR_BITS'(1) : wr_ptr_q;
      rd_ptr_d    = rd_fire ? rd_ptr_q + PTR_BITS'(1) : rd_ptr_q;
      count_d     = count_q;
      proto_err_d = proto_err_q | miss | stray;
      case ({wr_fire, rd_fire})
         2'b10:   count_d = count_q + (PTR_BITS+1)'(1);
         2'b01:   count_d = count_q - (PTR_BITS+1)'(1);
         default: count_d = count_q;
      endcase
   end

   // Control state; rst wins over any beat in flight.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
         exp_vld_q   <= 1'b0;
         exp_idx_q   <= '0;
         proto_err_q <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         count_q     <= count_d;
         exp_vld_q   <= |grant;
         exp_idx_q   <= grant_idx;
         proto_err_q <= proto_err_d;
      end
   end

   // Event storage; contents are only observable through a valid pointer.
   always_ff @(posedge clk) begin
      if (!rst && wr_fire) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

   assign src_grant = grant;
   assign rd_valid  = (count_q != '0);
   assign rd_event  = rd_valid ? mem_q[rd_ptr_q] : '0;
   assign count     = count_q;
   assign proto_err = proto_err_q;

endmodule

// File: tb/tb_dvs_event_fifo_arbiter.sv
// Directed bench for dvs_event_fifo_arbiter with a behavioural two-source responder.
// Latency: sources answer a grant seen in cycle T with a write beat in T+1.
// Backpressure: reader readiness is driven per scenario.
module tb_dvs_event_fifo_arbiter;
   import dvs_ravens_pkg::*;

   localparam int NS    = 2;
   localparam int DEPTH = 16;

   logic                     clk = 1'b0;
   logic                     rst;
   logic [NS-1:0]            src_req;
   logic [NS-1:0]            src_grant;
   logic [NS-1:0]            src_wr_en;
   logic [NS*EVENT_BITS-1:0] src_event;
   logic                     rd_valid;
   logic                     rd_ready;
   logic [EVENT_BITS-1:0]    rd_event;
   logic [4:0]               count;
   logic                     proto_err;

   always #5 clk = ~clk;

   dvs_event_fifo_arbiter #(.NUM_SRC(NS), .DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .src_req   (src_req),
      .src_grant (src_grant),
      .src_wr_en (src_wr_en),
      .src_event (src_event),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_event  (rd_event),
      .count     (count),
      .proto_err (proto_err)
   );

   int n_checks = 0;
   int n_pass   = 0;

   logic [NS-1:0]         last_grant  = '0;
   logic                  suppress_wr = 1'b0;
   int                    seq         = 0;
   logic [EVENT_BITS-1:0] got_q[$];
   logic [NS-1:0]         gnt_log[$];

   // Event payload: tag nibble A+source, then a running sequence number.
   function automatic logic [EVENT_BITS-1:0] ev_of(input int src, input int s);
      return {4'(4'hA + src), 12'(s)};
   endfunction

   function automatic int grants_in_log();
      int n = 0;
      foreach (gnt_log[i]) if (gnt_log[i] != '0) n++;
      return n;
   endfunction

   // One clock: record a pop, advance, then let sources answer last cycle's grant.
   task automatic step();
      if (!rst && rd_valid && rd_ready) got_q.push_back(rd_event);
      @(posedge clk);
      #1;
      src_wr_en = '0;
      src_event = '0;
      for (int i = 0; i < NS; i++) begin
         if (last_grant[i] && !suppress_wr) begin
            src_wr_en[i]                         = 1'b1;
            src_event[i*EVENT_BITS +: EVENT_BITS] = ev_of(i, seq);
            seq++;
         end
      end
      last_grant = src_grant;
      gnt_log.push_back(src_grant);
   endtask

   task automatic do_reset();
      rst         = 1'b1;
      src_req     = '0;
      rd_ready    = 1'b0;
      suppress_wr = 1'b0;
      step();
      step();
      rst = 1'b0;
      seq = 0;
      got_q.delete();
      gnt_log.delete();
   endtask

   task automatic test_reset();
      rst = 1'b1; src_req = '0; rd_ready = 1'b0;
      src_wr_en = '0; src_event = '0;
      step();
      step();
      n_checks++; if (src_grant !== 2'b00) $display("FAIL reset_grant got=%b want=00", src_grant); else n_pass++;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL reset_rd_valid got=%b want=0", rd_valid); else n_pass++;
      n_checks++; if (count !== 5'd0) $display("FAIL reset_count got=%0d want=0", count); else n_pass++;
      n_checks++; if (proto_err !== 1'b0) $display("FAIL reset_proto_err got=%b want=0", proto_err); else n_pass++;
      n_checks++; if (rd_event !== 16'h0000) $display("FAIL reset_rd_event got=%h want=0000", rd_event); else n_pass++;
      rst = 1'b0;
      step();
      n_checks++; if (src_grant !== 2'b00) $display("FAIL idle_grant got=%b want=00", src_grant); else n_pass++;
   endtask

   task automatic test_single();
      do_reset();
      src_req = 2'b01;
      step();
      n_checks++; if (src_grant !== 2'b01) $display("FAIL single_grant got=%b want=01", src_grant); else n_pass++;
      src_req = 2'b00;
      step();
      n_checks++; if (src_grant !== 2'b00) $display("FAIL single_grant_pulse got=%b want=00", src_grant); else n_pass++;
      n_checks++; if (count !== 5'd0) $display("FAIL single_count_before got=%0d want=0", count); else n_pass++;
      step();
      n_checks++; if (count !== 5'd1) $display("FAIL single_count got=%0d want=1", count); else n_pass++;
      n_checks++; if (rd_valid !== 1'b1) $display("FAIL single_rd_valid got=%b want=1", rd_valid); else n_pass++;
      n_checks++; if (rd_event !== 16'hA000) $display("FAIL single_rd_event got=%h want=a000", rd_event); else n_pass++;
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      n_checks++; if (count !== 5'd0) $display("FAIL single_count_pop got=%0d want=0", count); else n_pass++;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL single_empty got=%b want=0", rd_valid); else n_pass++;
      n_checks++; if (got_q.size() != 1) $display("FAIL single_pop_count got=%0d want=1", got_q.size()); else n_pass++;
      n_checks++; if (proto_err !== 1'b0) $display("FAIL single_proto_err got=%b want=0", proto_err); else n_pass++;
   endtask

   task automatic test_alternate();
      int order_err = 0;
      int consec_err = 0;
      int g = 0;
      do_reset();
      src_req = 2'b11;
      for (int i = 0; i < 40; i++) step();
      for (int i = 0; i < gnt_log.size(); i++) begin
         if (gnt_log[i] != '0) begin
            if (gnt_log[i] !== ((g % 2 == 0) ? 2'b01 : 2'b10)) order_err++;
            g++;
         end
         if (i > 0 && gnt_log[i] != '0 && gnt_log[i] === gnt_log[i-1]) consec_err++;
      end
      n_checks++; if (g != DEPTH) $display("FAIL alt_grant_total got=%0d want=%0d", g, DEPTH); else n_pass++;
      n_checks++; if (order_err != 0) $display("FAIL alt_order got=%0d bad want=0", order_err); else n_pass++;
      n_checks++; if (consec_err != 0) $display("FAIL alt_consecutive got=%0d want=0", consec_err); else n_pass++;
      n_checks++; if (count !== 5'd16) $display("FAIL alt_full_count got=%0d want=16", count); else n_pass++;
      n_checks++; if (rd_event !== 16'hA000) $display("FAIL alt_head got=%h want=a000", rd_event); else n_pass++;
   endtask

   task automatic test_full_backpressure();
      gnt_log.delete();
      for (int i = 0; i < 5; i++) step();
      n_checks++; if (grants_in_log() != 0) $display("FAIL full_no_grant got=%0d want=0", grants_in_log()); else n_pass++;
      n_checks++; if (count !== 5'd16) $display("FAIL full_hold_count got=%0d want=16", count); else n_pass++;
      gnt_log.delete();
      rd_ready = 1'b1;
      step();
      rd_ready = 1'b0;
      for (int i = 0; i < 6; i++) step();
      n_checks++; if (grants_in_log() != 1) $display("FAIL full_one_grant got=%0d want=1", grants_in_log()); else n_pass++;
      n_checks++; if (gnt_log[0] !== 2'b01) $display("FAIL full_grant_src got=%b want=01", gnt_log[0]); else n_pass++;
      n_checks++; if (count !== 5'd16) $display("FAIL full_refill got=%0d want=16", count); else n_pass++;
      n_checks++; if (got_q.size() != 1 || got_q[0] !== 16'hA000) $display("FAIL full_pop got_n=%0d want a000 once", got_q.size()); else n_pass++;
   endtask

   // Grant-to-write spans two edges, so a full buffer drained every cycle settles two below DEPTH.
   task automatic test_stream();
      int lo = 99;
      int hi = 0;
      int n = 0;
      rd_ready = 1'b1;
      src_req  = 2'b11;
      while (got_q.size() < 65 && n < 300) begin
         step();
         n++;
         if (int'(count) < lo) lo = int'(count);
         if (int'(count) > hi) hi = int'(count);
      end
      rd_ready = 1'b0;
      src_req  = 2'b00;
      n_checks++; if (got_q.size() < 65) $display("FAIL stream_timeout got=%0d want=65", got_q.size()); else n_pass++;
      n_checks++; if (hi > DEPTH) $display("FAIL stream_overflow got=%0d want<=16", hi); else n_pass++;
      n_checks++; if (lo < DEPTH - 2) $display("FAIL stream_low got=%0d want>=14", lo); else n_pass++;
      for (int k = 0; k < 65 && k < got_q.size(); k++) begin
         n_checks++;
         if (got_q[k] !== ev_of(k % 2, k)) $display("FAIL stream_data[%0d] got=%h want=%h", k, got_q[k], ev_of(k % 2, k));
         else n_pass++;
      end
   endtask

   task automatic test_wrap();
      int n = 0;
      do_reset();
      src_req = 2'b11;
      while (got_q.size() < 40 && n < 800) begin
         rd_ready = 1'($urandom_range(0, 1));
         step();
         n++;
         if (grants_in_log() >= 40) src_req = 2'b00;
      end
      rd_ready = 1'b0;
      n_checks++; if (got_q.size() != 40) $display("FAIL wrap_count got=%0d want=40", got_q.size()); else n_pass++;
      n_checks++; if (grants_in_log() != 40) $display("FAIL wrap_grants got=%0d want=40", grants_in_log()); else n_pass++;
      n_checks++; if (count !== 5'd0) $display("FAIL wrap_drained got=%0d want=0", count); else n_pass++;
      for (int k = 0; k < got_q.size(); k++) begin
         n_checks++;
         if (got_q[k] !== ev_of(k % 2, k)) $display("FAIL wrap_data[%0d] got=%h want=%h", k, got_q[k], ev_of(k % 2, k));
         else n_pass++;
      end
   endtask

   task automatic test_proto_and_reset();
      do_reset();
      suppress_wr = 1'b1;
      src_req = 2'b10;
      step();
      src_req = 2'b00;
      n_checks++; if (src_grant !== 2'b10) $display("FAIL proto_grant got=%b want=10", src_grant); else n_pass++;
      step();
      step();
      n_checks++; if (proto_err !== 1'b1) $display("FAIL proto_missing_beat got=%b want=1", proto_err); else n_pass++;
      n_checks++; if (count !== 5'd0) $display("FAIL proto_count got=%0d want=0", count); else n_pass++;
      do_reset();
      n_checks++; if (proto_err !== 1'b0) $display("FAIL proto_cleared got=%b want=0", proto_err); else n_pass++;
      step();
      src_wr_en = 2'b10;
      src_event = {16'hBEEF, 16'h0000};
      step();
      n_checks++; if (proto_err !== 1'b1) $display("FAIL proto_stray got=%b want=1", proto_err); else n_pass++;
      n_checks++; if (count !== 5'd0) $display("FAIL proto_stray_count got=%0d want=0", count); else n_pass++;
      src_req = 2'b11;
      for (int i = 0; i < 6; i++) step();
      n_checks++; if (count === 5'd0) $display("FAIL midrst_prefill got=%0d want>0", count); else n_pass++;
      rst = 1'b1;
      step();
      n_checks++; if (src_grant !== 2'b00) $display("FAIL midrst_grant got=%b want=00", src_grant); else n_pass++;
      n_checks++; if (rd_valid !== 1'b0) $display("FAIL midrst_rd_valid got=%b want=0", rd_valid); else n_pass++;
      n_checks++; if (count !== 5'd0) $display("FAIL midrst_count got=%0d want=0", count); else n_pass++;
      n_checks++; if (proto_err !== 1'b0) $display("FAIL midrst_proto got=%b want=0", proto_err); else n_pass++;
      n_checks++; if (rd_event !== 16'h0000) $display("FAIL midrst_rd_event got=%h want=0000", rd_event); else n_pass++;
      src_req = 2'b00;
      step();
      rst = 1'b0;
      step();
      step();
      n_checks++; if (count !== 5'd0) $display("FAIL midrst_beat_lost got=%0d want=0", count); else n_pass++;
      n_checks++; if (proto_err !== 1'b0) $display("FAIL midrst_proto_after got=%b want=0", proto_err); else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog_timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      test_reset();
      test_single();
      test_alternate();
      test_full_backpressure();
      test_stream();
      test_wrap();
      test_proto_and_reset();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
